// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing generator with sync polarity, pixel-clock
// divider, line/frame strobes and frame-boundary timing reprogramming. Rev 1.0
`default_nettype none

module video_timing_gen #(
  parameter int DATA_WIDTH = 10,
  parameter int H_DISPLAY  = 256,
  parameter int H_FRONT    = 7,
  parameter int H_SYNC     = 23,
  parameter int H_BACK     = 23,
  parameter int V_DISPLAY  = 240,
  parameter int V_BOTTOM   = 14,
  parameter int V_SYNC     = 3,
  parameter int V_TOP      = 5,
  parameter int HSYNC_POL  = 0,
  parameter int VSYNC_POL  = 0,
  parameter int PIX_DIV    = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [DATA_WIDTH-1:0] cfg_h_display,
  input  logic [DATA_WIDTH-1:0] cfg_h_front,
  input  logic [DATA_WIDTH-1:0] cfg_h_sync,
  input  logic [DATA_WIDTH-1:0] cfg_h_back,
  input  logic [DATA_WIDTH-1:0] cfg_v_display,
  input  logic [DATA_WIDTH-1:0] cfg_v_bottom,
  input  logic [DATA_WIDTH-1:0] cfg_v_sync,
  input  logic [DATA_WIDTH-1:0] cfg_v_top,
  output logic                  cfg_err,
  output logic                  pix_en,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  display_on,
  output logic                  line_start,
  output logic                  frame_start,
  output logic [DATA_WIDTH-1:0] hpos,
  output logic [DATA_WIDTH-1:0] vpos
);

  localparam int SW    = DATA_WIDTH + 2;
  localparam int DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic H_POL = 1'(HSYNC_POL != 0);
  localparam logic V_POL = 1'(VSYNC_POL != 0);
  localparam logic [SW-1:0] MAX_TOTAL = SW'(2 ** DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0] RESET_HMAX = DATA_WIDTH'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [DATA_WIDTH-1:0] RESET_VMAX = DATA_WIDTH'(V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP - 1);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] hd, hf, hs, hb, vd, vb, vs, vt;
  } timing_t;

  localparam timing_t RESET_CFG = '{
    hd: DATA_WIDTH'(H_DISPLAY), hf: DATA_WIDTH'(H_FRONT),
    hs: DATA_WIDTH'(H_SYNC),    hb: DATA_WIDTH'(H_BACK),
    vd: DATA_WIDTH'(V_DISPLAY), vb: DATA_WIDTH'(V_BOTTOM),
    vs: DATA_WIDTH'(V_SYNC),    vt: DATA_WIDTH'(V_TOP)
  };

  function automatic logic [SW-1:0] ext(input logic [DATA_WIDTH-1:0] x);
    return {2'b00, x};
  endfunction

  timing_t               active_cfg, pend_cfg, offered, use_cfg;
  logic                  pend_valid;
  logic                  tick, h_wrap, v_wrap, apply, offered_ok;
  logic [SW-1:0]         h_max, v_max, h_tot, v_tot;
  logic [SW-1:0]         hs_start, hs_end, vs_start, vs_end;
  logic [DATA_WIDTH-1:0] next_h, next_v;
  logic                  next_hs_act, next_vs_act, next_de;

  if (PIX_DIV > 1) begin : g_div
    logic [DIV_W-1:0] div_cnt;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) div_cnt <= '0;
      else if (tick) div_cnt <= '0;
      else div_cnt <= div_cnt + DIV_W'(1);
    end
    assign tick = (div_cnt == DIV_W'(PIX_DIV - 1));
  end else begin : g_no_div
    assign tick = 1'b1;
  end

  assign offered = '{
    hd: cfg_h_display, hf: cfg_h_front, hs: cfg_h_sync, hb: cfg_h_back,
    vd: cfg_v_display, vb: cfg_v_bottom, vs: cfg_v_sync, vt: cfg_v_top
  };
  assign cfg_ready = !pend_valid;

  always_comb begin
    h_max  = ext(active_cfg.hd) + ext(active_cfg.hf) + ext(active_cfg.hs) + ext(active_cfg.hb) - SW'(1);
    v_max  = ext(active_cfg.vd) + ext(active_cfg.vb) + ext(active_cfg.vs) + ext(active_cfg.vt) - SW'(1);
    h_wrap = (ext(hpos) == h_max);
    v_wrap = (ext(vpos) == v_max);
    apply  = tick && h_wrap && v_wrap && pend_valid;
    // The first pixel of a reprogrammed frame is already described with the new timing.
    use_cfg = apply ? pend_cfg : active_cfg;
    next_h  = h_wrap ? '0 : hpos + DATA_WIDTH'(1);
    next_v  = h_wrap ? (v_wrap ? '0 : vpos + DATA_WIDTH'(1)) : vpos;
    hs_start = ext(use_cfg.hd) + ext(use_cfg.hf);
    hs_end   = hs_start + ext(use_cfg.hs) - SW'(1);
    vs_start = ext(use_cfg.vd) + ext(use_cfg.vb);
    vs_end   = vs_start + ext(use_cfg.vs) - SW'(1);
    next_hs_act = (ext(next_h) >= hs_start) && (ext(next_h) <= hs_end);
    next_vs_act = (ext(next_v) >= vs_start) && (ext(next_v) <= vs_end);
    next_de     = (next_h < use_cfg.hd) && (next_v < use_cfg.vd);
    h_tot = ext(offered.hd) + ext(offered.hf) + ext(offered.hs) + ext(offered.hb);
    v_tot = ext(offered.vd) + ext(offered.vb) + ext(offered.vs) + ext(offered.vt);
    offered_ok = (offered.hd != '0) && (offered.hs != '0) && (offered.vd != '0) &&
                 (offered.vs != '0) && (h_tot <= MAX_TOTAL) && (v_tot <= MAX_TOTAL);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active_cfg  <= RESET_CFG;
      pend_cfg    <= '0;
      pend_valid  <= 1'b0;
      cfg_err     <= 1'b0;
      pix_en      <= 1'b0;
      hpos        <= RESET_HMAX;
      vpos        <= RESET_VMAX;
      hsync       <= ~H_POL;
      vsync       <= ~V_POL;
      display_on  <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pix_en  <= tick;
      cfg_err <= 1'b0;
      if (tick) begin
        hpos        <= next_h;
        vpos        <= next_v;
        hsync       <= next_hs_act ^ ~H_POL;
        vsync       <= next_vs_act ^ ~V_POL;
        display_on  <= next_de;
        line_start  <= (next_h == '0);
        frame_start <= (next_h == '0) && (next_v == '0);
      end
      if (apply) begin
        active_cfg <= pend_cfg;
        pend_valid <= 1'b0;
      end
      // Acceptance needs cfg_ready, so it never coincides with an apply.
      if (cfg_valid && !pend_valid) begin
        if (offered_ok) begin
          pend_cfg   <= offered;
          pend_valid <= 1'b1;
        end else begin
          cfg_err <= 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: table-driven raster checks with a handshake scoreboard. Rev 1.0
`default_nettype none

module tb_video_timing_gen;

  typedef struct {
    int cyc; int h; int v;
    bit hs; bit vs; bit de; bit ls; bit fs; bit pe; bit rdy;
  } vec_t;

  typedef struct { bit err; bit rdy; } hs_exp_t;

  logic clk = 1'b0;
  logic rst_a_n = 1'b0, rst_b_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  hs_exp_t qa[$], qb[$];

  // dut_a: default timing; dut_c: same with active-high syncs; dut_b: small timing, /3 divider
  logic        va = 1'b0, vb = 1'b0;
  logic [9:0]  ca [8];
  logic [10:0] cb [8];
  logic        rdy_a, err_a, pe_a, hs_a, vs_a, de_a, ls_a, fs_a;
  logic [9:0]  hp_a, vp_a;
  logic        rdy_c, err_c, pe_c, hs_c, vs_c, de_c, ls_c, fs_c;
  logic [9:0]  hp_c, vp_c;
  logic        rdy_b, err_b, pe_b, hs_b, vs_b, de_b, ls_b, fs_b;
  logic [10:0] hp_b, vp_b;

  video_timing_gen dut_a (
    .clk(clk), .reset_n(rst_a_n), .cfg_valid(va), .cfg_ready(rdy_a),
    .cfg_h_display(ca[0]), .cfg_h_front(ca[1]), .cfg_h_sync(ca[2]), .cfg_h_back(ca[3]),
    .cfg_v_display(ca[4]), .cfg_v_bottom(ca[5]), .cfg_v_sync(ca[6]), .cfg_v_top(ca[7]),
    .cfg_err(err_a), .pix_en(pe_a), .hsync(hs_a), .vsync(vs_a), .display_on(de_a),
    .line_start(ls_a), .frame_start(fs_a), .hpos(hp_a), .vpos(vp_a));

  video_timing_gen #(.HSYNC_POL(1), .VSYNC_POL(1)) dut_c (
    .clk(clk), .reset_n(rst_a_n), .cfg_valid(1'b0), .cfg_ready(rdy_c),
    .cfg_h_display(10'd0), .cfg_h_front(10'd0), .cfg_h_sync(10'd0), .cfg_h_back(10'd0),
    .cfg_v_display(10'd0), .cfg_v_bottom(10'd0), .cfg_v_sync(10'd0), .cfg_v_top(10'd0),
    .cfg_err(err_c), .pix_en(pe_c), .hsync(hs_c), .vsync(vs_c), .display_on(de_c),
    .line_start(ls_c), .frame_start(fs_c), .hpos(hp_c), .vpos(vp_c));

  video_timing_gen #(.DATA_WIDTH(11), .PIX_DIV(3),
                     .H_DISPLAY(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
                     .V_DISPLAY(8), .V_BOTTOM(1), .V_SYNC(2), .V_TOP(1)) dut_b (
    .clk(clk), .reset_n(rst_b_n), .cfg_valid(vb), .cfg_ready(rdy_b),
    .cfg_h_display(cb[0]), .cfg_h_front(cb[1]), .cfg_h_sync(cb[2]), .cfg_h_back(cb[3]),
    .cfg_v_display(cb[4]), .cfg_v_bottom(cb[5]), .cfg_v_sync(cb[6]), .cfg_v_top(cb[7]),
    .cfg_err(err_b), .pix_en(pe_b), .hsync(hs_b), .vsync(vs_b), .display_on(de_b),
    .line_start(ls_b), .frame_start(fs_b), .hpos(hp_b), .vpos(vp_b));

  function automatic logic [30:0] pk(int h, int v, bit hs, bit vs, bit de, bit ls, bit fs, bit pe, bit rdy);
    return {12'(h), 12'(v), hs, vs, de, ls, fs, pe, rdy};
  endfunction

  function automatic logic [30:0] act_a();
    return pk(int'(hp_a), int'(vp_a), hs_a, vs_a, de_a, ls_a, fs_a, pe_a, rdy_a);
  endfunction
  function automatic logic [30:0] act_c();
    return pk(int'(hp_c), int'(vp_c), hs_c, vs_c, de_c, ls_c, fs_c, pe_c, rdy_c);
  endfunction
  function automatic logic [30:0] act_b();
    return pk(int'(hp_b), int'(vp_b), hs_b, vs_b, de_b, ls_b, fs_b, pe_b, rdy_b);
  endfunction

  task automatic check(input string name, input int cyc, input logic [30:0] act, input logic [30:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual h=%0d v=%0d hs/vs/de/ls/fs/pe/rdy=%b required h=%0d v=%0d hs/vs/de/ls/fs/pe/rdy=%b",
               name, cyc, act[30:19], act[18:7], act[6:0], exp[30:19], exp[18:7], exp[6:0]);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic step(inout int c);
    @(posedge clk);
    #1;
    c++;
  endtask

  task automatic step_to(inout int c, input int target);
    if (c > target) begin
      failures++;
      $display("FAIL order target=%0d already at %0d", target, c);
    end
    while (c < target) step(c);
  endtask

  task automatic run_a(inout int c, input vec_t t, input bit with_c);
    step_to(c, t.cyc);
    check("raster_a", c, act_a(), pk(t.h, t.v, t.hs, t.vs, t.de, t.ls, t.fs, t.pe, t.rdy));
    if (with_c)
      check("raster_c_pol", c, act_c(), pk(t.h, t.v, !t.hs, !t.vs, t.de, t.ls, t.fs, t.pe, 1'b1));
  endtask

  task automatic run_b(inout int c, input vec_t t);
    step_to(c, t.cyc);
    check("raster_b", c, act_b(), pk(t.h, t.v, t.hs, t.vs, t.de, t.ls, t.fs, t.pe, t.rdy));
  endtask

  task automatic pop_a(input string name);
    hs_exp_t e;
    if (qa.size() == 0) begin
      failures++;
      $display("FAIL %s scoreboard empty", name);
    end else begin
      e = qa.pop_front();
      check_bit({name, "_err"}, err_a, e.err);
      check_bit({name, "_rdy"}, rdy_a, e.rdy);
    end
  endtask

  vec_t tab_a[18] = '{
    '{1, 0, 0, 1,1,1,1,1, 1,1},       '{2, 1, 0, 1,1,1,0,0, 1,1},
    '{256, 255, 0, 1,1,1,0,0, 1,1},   '{257, 256, 0, 1,1,0,0,0, 1,1},
    '{263, 262, 0, 1,1,0,0,0, 1,1},   '{264, 263, 0, 0,1,0,0,0, 1,1},
    '{286, 285, 0, 0,1,0,0,0, 1,1},   '{287, 286, 0, 1,1,0,0,0, 1,1},
    '{309, 308, 0, 1,1,0,0,0, 1,1},   '{310, 0, 1, 1,1,1,1,0, 1,1},
    '{73852, 0, 239, 1,1,1,1,0, 1,1}, '{74161, 0, 240, 1,1,0,1,0, 1,1},
    '{78178, 0, 253, 1,1,0,1,0, 1,1}, '{78487, 0, 254, 1,0,0,1,0, 1,1},
    '{79413, 308, 256, 1,0,0,0,0, 1,1}, '{79414, 0, 257, 1,1,0,1,0, 1,1},
    '{80958, 308, 261, 1,1,0,0,0, 1,1}, '{80959, 0, 0, 1,1,1,1,1, 1,1}
  };

  vec_t tab_b1[10] = '{
    '{3, 0, 0, 1,1,1,1,1, 1,1},  '{4, 0, 0, 1,1,1,1,1, 0,1},
    '{5, 0, 0, 1,1,1,1,1, 0,1},  '{6, 1, 0, 1,1,1,0,0, 1,1},
    '{48, 15, 0, 1,1,1,0,0, 1,1}, '{51, 16, 0, 1,1,0,0,0, 1,1},
    '{57, 18, 0, 0,1,0,0,0, 1,1}, '{65, 20, 0, 0,1,0,0,0, 0,1},
    '{66, 21, 0, 1,1,0,0,0, 1,1}, '{72, 0, 1, 1,1,1,1,0, 1,1}
  };

  vec_t tab_b2[16] = '{
    '{555, 0, 8, 1,1,0,1,0, 1,0},     '{624, 0, 9, 1,0,0,1,0, 1,0},
    '{759, 22, 10, 1,0,0,0,0, 1,0},   '{762, 0, 11, 1,1,0,1,0, 1,0},
    '{828, 22, 11, 1,1,0,0,0, 1,0},   '{830, 22, 11, 1,1,0,0,0, 0,0},
    '{831, 0, 0, 1,1,1,1,1, 1,1},     '{2748, 639, 0, 1,1,1,0,0, 1,1},
    '{2751, 640, 0, 1,1,0,0,0, 1,1},  '{2796, 655, 0, 1,1,0,0,0, 1,1},
    '{2799, 656, 0, 0,1,0,0,0, 1,1},  '{3084, 751, 0, 0,1,0,0,0, 1,1},
    '{3087, 752, 0, 1,1,0,0,0, 1,1},  '{3228, 799, 0, 1,1,0,0,0, 1,1},
    '{3231, 0, 1, 1,1,1,1,0, 1,1},    '{3232, 0, 1, 1,1,1,1,0, 0,1}
  };

  initial begin
    #1_500_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) begin
      ca[i] = '0;
      cb[i] = '0;
    end
    #23;
    check("reset_a", 0, act_a(), pk(308, 261, 1,1,0,0,0,0, 1));
    check("reset_c", 0, act_c(), pk(308, 261, 0,0,0,0,0,0, 1));
    check("reset_b", 0, act_b(), pk(22, 11, 1,1,0,0,0,0, 1));
    check_bit("reset_err_a", err_a, 1'b0);
    @(negedge clk);
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;
    fork
      begin : seq_a
        int c = 0;
        foreach (tab_a[i]) run_a(c, tab_a[i], 1'b1);
        // oversize line total: rejected with a single error pulse
        step_to(c, 80960);
        ca = '{10'd1000, 10'd50, 10'd25, 10'd25, 10'd240, 10'd14, 10'd3, 10'd5};
        va = 1'b1;
        qa.push_back('{err: 1'b1, rdy: 1'b1});
        step(c);
        va = 1'b0;
        pop_a("bad_cfg");
        qa.push_back('{err: 1'b0, rdy: 1'b1});
        step(c);
        pop_a("bad_cfg_after");
        run_a(c, '{81268, 0, 1, 1,1,1,1,0, 1,1}, 1'b0);
        // line total of exactly 2^DATA_WIDTH is legal
        step_to(c, 81270);
        ca = '{10'd1000, 10'd0, 10'd24, 10'd0, 10'd8, 10'd0, 10'd1, 10'd0};
        va = 1'b1;
        qa.push_back('{err: 1'b0, rdy: 1'b0});
        step(c);
        va = 1'b0;
        pop_a("edge_cfg");
        run_a(c, '{81368, 100, 1, 1,1,1,0,0, 1,0}, 1'b0);
        #2;
        rst_a_n = 1'b0;
        #1;
        check("async_reset_a", c, act_a(), pk(308, 261, 1,1,0,0,0,0, 1));
        @(negedge clk);
        rst_a_n = 1'b1;
        c = 0;
        run_a(c, '{1, 0, 0, 1,1,1,1,1, 1,1}, 1'b0);
        run_a(c, '{101, 100, 0, 1,1,1,0,0, 1,1}, 1'b0);
        run_a(c, '{310, 0, 1, 1,1,1,1,0, 1,1}, 1'b0);
      end
      begin : seq_b
        int c = 0;
        foreach (tab_b1[i]) run_b(c, tab_b1[i]);
        step_to(c, 100);
        cb = '{11'd640, 11'd16, 11'd96, 11'd48, 11'd480, 11'd10, 11'd2, 11'd33};
        vb = 1'b1;
        qb.push_back('{err: 1'b0, rdy: 1'b0});
        step(c);
        vb = 1'b0;
        if (qb.size() == 0) begin
          failures++;
          $display("FAIL mid_cfg scoreboard empty");
        end else begin
          hs_exp_t e;
          e = qb.pop_front();
          check_bit("mid_cfg_err", err_b, e.err);
          check_bit("mid_cfg_rdy", rdy_b, e.rdy);
        end
        foreach (tab_b2[i]) run_b(c, tab_b2[i]);
      end
    join
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
